// File: rtl/instruction_fetch_queue_if.sv
// Fetch/decode boundary bundle: imem address/data, redirect, and queue head handshake.
// Latency: none, wires only.
// Backpressure: out_ready from decode stalls the queue head; a full queue stalls fetch.
interface instruction_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_adr;
  logic [31:0]   imem_instruction;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instruction;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_plus4;
  logic [CW-1:0] count;

  // Fetch-queue side.
  modport master (
    output imem_adr,
    input  imem_instruction,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc,
    output out_pc_plus4,
    output count
  );

  // Memory / decode / branch-resolution side.
  modport slave (
    input  imem_adr,
    output imem_instruction,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc,
    input  out_pc_plus4,
    input  count
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Fetches word-aligned PCs from a combinational imem into an in-order {instr, pc} queue.
// Latency: 1 cycle fetch-to-head; redirect costs 2 cycles to the first target word.
// Backpressure: out_ready low fills the queue in DEPTH cycles, then fetch_pc stalls.
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                       clk,
  input logic                       rst,
  instruction_fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  entry_t        store_q [DEPTH];
  entry_t        store_d [DEPTH];

  logic   push;
  logic   pop;
  logic   head_vld;
  entry_t head;

  // Low address bits of the redirect target are dropped by word alignment.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign head_vld = (count_q != '0);
  assign head     = store_q[rd_ptr_q];

  // Handshake decode: redirect suppresses both push and pop; a full queue
  // may still push when the head leaves in the same cycle.
  always_comb begin
    pop  = head_vld & bus.out_ready & ~bus.redirect;
    push = ~bus.redirect & ((count_q != FULL_CNT) | pop);
  end

  // Next-state for fetch PC, pointers, occupancy and storage.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    store_d    = store_q;

    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        store_d[wr_ptr_q] = '{instr: bus.imem_instruction, pc: fetch_pc_q};
        wr_ptr_d          = wr_ptr_q + 1'b1;
        fetch_pc_d        = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers; reset clears storage so stale head fields read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= store_d[i];
      end
    end
  end

  // Head and fetch address are presented combinationally.
  always_comb begin
    bus.imem_adr        = fetch_pc_q;
    bus.out_valid       = head_vld;
    bus.out_instruction = head.instr;
    bus.out_pc          = head.pc;
    bus.out_pc_plus4    = head.pc + 32'd4;
    bus.count           = count_q;
  end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch stage that drives the word-aligned program counter into the byte-addressed instruction memory and captures the returned 32-bit instruction words into a small in-order prefetch queue. The queue holds each word with its PC. Decode consumes entries through a valid/ready handshake. A redirect input from branch/jump resolution flushes the queue and restarts fetch at a new target. The block sits between the instruction memory (combinational read, same cycle) and the decode/register-file stage.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000: fetch PC after reset; must be word-aligned
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- imem_adr  out  32  fetch address to instruction memory; always word-aligned
- imem_instruction  in  32  word returned combinationally for imem_adr
- redirect  in  1  flush queue, restart fetch at redirect_pc
- redirect_pc  in  32  new fetch target; bits [1:0] ignored
- out_valid  out  1  queue head holds a valid entry
- out_ready  in  1  decode accepts head this cycle
- out_instruction  out  32  head instruction word
- out_pc  out  32  PC of head instruction
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation
- State: fetch_pc register, DEPTH-entry storage of {instruction, pc}, write pointer, read pointer, count.
- imem_adr = fetch_pc, combinational. imem_instruction is sampled in the same cycle.
- pop = out_valid & out_ready & ~redirect.
- push = ~redirect & (count < DEPTH | pop). A full queue with a simultaneous pop still accepts a push, so streaming has no bubble.
- On push: write {imem_instruction, fetch_pc} at the write pointer, advance the write pointer, and set fetch_pc <= fetch_pc + 4. The PC wraps from 32'hFFFF_FFFC to 0.
- On pop: advance the read pointer.
- count next = count + push − pop.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- When neither push nor pop occurs (full with no pop), fetch_pc, the pointers and the storage hold.
- Redirect has priority over everything else:
  - the queue empties: count <= 0 and both pointers <= 0;
  - fetch_pc <= {redirect_pc[31:2], 2'b00};
  - no push and no pop happen that cycle, even if out_ready = 1.
- Outputs come combinationally from the entry at the read pointer. out_valid = (count != 0).
- While out_valid = 0, out_instruction and out_pc show the stale slot contents. Decode must ignore them.
- Reset (rst = 0) asynchronously sets:
  - fetch_pc = RESET_PC, so imem_adr = RESET_PC;
  - pointers = 0, count = 0;
  - all storage = 0, so out_valid = 0, out_instruction = 0, out_pc = 0, out_pc_plus4 = 4.
- Reset asserted mid-stream discards every queued entry. No partial state survives.

## Timing
- Fetch-to-visible latency is 1 cycle. The word at fetch_pc is pushed at edge N and appears on out_* after edge N, when it is the head.
- After reset deassertion: the first edge pushes RESET_PC, and out_valid = 1 after that edge.
- Redirect asserted in cycle N:
  - after edge N: queue is empty, out_valid = 0, imem_adr = target;
  - after edge N+1: out_valid = 1 and out_pc = target.
- Redirect penalty is 2 cycles from assertion to a valid target instruction.
- Sustained throughput is 1 instruction/cycle while out_ready = 1.
- With out_ready = 0 the queue fills in DEPTH cycles. fetch_pc then stalls at (last pushed PC + 4).
- Combinational path out_ready → push → fetch_pc enable is intentional.

## Test plan
- Reset, then memory at 0x0 / 0x4 / 0x8 = 32'h00500093 / 32'h00A00113 / 32'h002081B3, out_ready = 1 → consecutive cycles show out_pc = 0, 4, 8 with matching words, count stays 1, out_pc_plus4 = out_pc + 4.
- Hold out_ready = 0 for 6 cycles with DEPTH = 4 → count = 1, 2, 3, 4, 4, 4; imem_adr freezes at 0x10. Then out_ready = 1 → heads 0x0, 0x4, 0x8, 0xC in order; count stays 4 while pushes continue.
- Full queue, out_ready = 1 and redirect = 1 with redirect_pc = 32'h0000_0103 in the same cycle → no pop is counted; next cycle count = 0 and imem_adr = 0x100; the cycle after, out_pc = 0x100.
- RESET_PC = 32'hFFFF_FFF8, out_ready = 1 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_plus4 for FFFF_FFFC = 0.
- rst pulsed low asynchronously between edges with count = 3 → out_valid drops immediately, count = 0, imem_adr = RESET_PC. After release, the first entry has out_pc = RESET_PC.
